regfile_wb_scheduler: RTL and testbench
=======================================

# regfile_wb_scheduler

Write-back scheduler and scoreboard for the 32x32 register file's single write port. It arbitrates between a single-cycle ALU write-back source (A) and a long-latency load/multi-cycle write-back source (B), and drives the register file's write port from registered outputs. It also tracks the destination registers of outstanding long-latency operations and produces the issue-stall signal for RAW/WAW hazards, outstanding-count limits and B-starvation relief.

## Interface
Parameters:
- MAX_OUTSTANDING, 4: maximum in-flight long operations; legal range 1..15.
- STARVE_LIMIT, 8: cycles B may wait before issue is throttled; legal range 1..255.

Ports:
- i_clk  in  1  clock; all state updates on its rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_issue_valid  in  1  decode stage presents an instruction.
- i_issue_rd  in  5  destination register.
- i_issue_rs1  in  5  source register 1.
- i_issue_rs2  in  5  source register 2.
- i_issue_use_rs1  in  1  instruction reads rs1.
- i_issue_use_rs2  in  1  instruction reads rs2.
- i_issue_long  in  1  instruction completes through source B.
- o_issue_stall  out  1  combinational; issue is not accepted this cycle.
- i_wba_valid  in  1  source A write request; always accepted.
- i_wba_rd  in  5  source A destination.
- i_wba_data  in  32  source A data.
- i_wbb_valid  in  1  source B write request.
- i_wbb_rd  in  5  source B destination.
- i_wbb_data  in  32  source B data.
- o_wbb_ready  out  1  combinational; source B write accepted when valid and ready.
- o_rd_wren  out  1  register file write enable.
- o_rd_addr  out  5  register file write address.
- o_rd_data  out  32  register file write data.
- o_busy  out  32  scoreboard; bit n set means a long write to xn is pending.
- o_sb_err  out  1  sticky; set when B writes a register whose busy bit is clear.

## Operation
- Issue accept: issue_acc = i_issue_valid && !o_issue_stall.
- o_issue_stall = i_issue_valid && (hazard || full || starve_hold).
  - hazard: (use_rs1 && busy[rs1]) || (use_rs2 && busy[rs2]) || busy[rd].
  - full: i_issue_long && outstanding == MAX_OUTSTANDING.
  - The stall decision uses registered busy only; a clear in the same cycle does not bypass it.
- Scoreboard:
  - busy[0] is hardwired 0.
  - On issue_acc && long && rd != 0, set busy[rd].
  - On B accept, clear busy[i_wbb_rd].
  - A never touches busy.
- Outstanding counter:
  - +1 on issue_acc && long, including rd = 0.
  - -1 on B accept.
  - Both in the same cycle: unchanged.
  - Never below 0 or above MAX_OUTSTANDING.
- Arbitration:
  - A has fixed priority: o_wbb_ready = !i_wba_valid.
  - Exactly one source drives the port per cycle.
- Starvation:
  - wait_cnt (8-bit) increments each cycle i_wbb_valid && !o_wbb_ready, and resets to 0 on B accept or when B is not valid.
  - When wait_cnt reaches STARVE_LIMIT, starve_hold sets; it blocks all issue so A traffic drains.
  - starve_hold clears on the cycle after B accept.
- Write port:
  - The selected write is registered: o_rd_wren = 1, with addr and data, one cycle after acceptance.
  - Writes with rd = 0 complete their handshake (and clear nothing) but produce o_rd_wren = 0.
- o_sb_err sets on B accept with busy[i_wbb_rd] == 0 and i_wbb_rd != 0.
  - It clears only on reset.

## Timing
- Reset (asynchronous assert, synchronous release): o_rd_wren = 0, o_rd_addr = 0, o_rd_data = 0, o_busy = 0, o_sb_err = 0, outstanding = 0, wait_cnt = 0, starve_hold = 0.
- Reset asserted mid-operation discards every pending write and scoreboard bit immediately.
- Write latency: request accepted in cycle N produces o_rd_* in cycle N+1.
- Busy-set visibility:
  - A bit set by an accepted issue in cycle N is visible on o_busy, and stalls dependents, from cycle N+1.
  - A bit cleared by B accept in cycle N drops in N+1; a dependent issues no earlier than N+1.
  - The register file write lands at the N+1 edge, so data is readable in N+2.
- Simultaneous events:
  - Issue to rd and B accept to the same rd in one cycle is impossible, because busy[rd] stalls the issue.
  - A and B both valid: A is written; B stays pending and must hold its valid and payload stable.
- Starvation: if A is continuously valid, B is accepted no later than STARVE_LIMIT + (A pipeline drain) cycles after it first asserts valid.

## Test plan
- Reset: drive i_reset_n = 0 mid-write -> all outputs 0 immediately; o_busy = 0 after release.
- Long issue rd = 5 (accepted in cycle 1), then an issue reading rs1 = 5 -> stalled; B writes x5 = 0xDEADBEEF in cycle 4 -> o_rd_wren = 1 at addr 5 in cycle 5; dependent issue accepted in cycle 5.
- Collision: A (x3 = 0x11) and B (x7 = 0x22) valid in the same cycle -> x3 written first with o_wbb_ready = 0; x7 written the next cycle.
- Outstanding limit: MAX_OUTSTANDING = 4 long issues to x1..x4, then a 5th long issue -> stalled; a short issue to x9 -> accepted; one B completion -> the 5th is accepted the next cycle.
- Starvation: A valid every cycle and B valid, STARVE_LIMIT = 8 -> after 8 waiting cycles o_issue_stall = 1 for any issue; B accepted once A drops; stall released the cycle after.
- x0 and errors:
  - Long issue rd = 0 -> o_busy stays 0 and outstanding increments.
  - B write to x0 -> o_rd_wren = 0.
  - B write to non-busy x12 -> o_sb_err = 1 and sticky.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Write-back arbiter and long-op scoreboard for the register file's single write port.
// Source A (ALU) has fixed priority; source B (long ops) is protected from starvation by throttling issue.
module regfile_wb_scheduler #(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned STARVE_LIMIT    = 8
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_issue_valid,
   input  logic [4:0]  i_issue_rd,
   input  logic [4:0]  i_issue_rs1,
   input  logic [4:0]  i_issue_rs2,
   input  logic        i_issue_use_rs1,
   input  logic        i_issue_use_rs2,
   input  logic        i_issue_long,
   output logic        o_issue_stall,
   input  logic        i_wba_valid,
   input  logic [4:0]  i_wba_rd,
   input  logic [31:0] i_wba_data,
   input  logic        i_wbb_valid,
   input  logic [4:0]  i_wbb_rd,
   input  logic [31:0] i_wbb_data,
   output logic        o_wbb_ready,
   output logic        o_rd_wren,
   output logic [4:0]  o_rd_addr,
   output logic [31:0] o_rd_data,
   output logic [31:0] o_busy,
   output logic        o_sb_err
);

   localparam logic [3:0] MAX_CNT    = 4'(MAX_OUTSTANDING);
   localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

   logic [31:0] busy_q, busy_d;
   logic [3:0]  out_cnt_q, out_cnt_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        starve_hold_q, starve_hold_d;
   logic        rd_wren_q, rd_wren_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        sb_err_q, sb_err_d;

   logic hazard;
   logic full;
   logic issue_long_acc;
   logic b_acc;

   // Stall is decided from registered busy only: a clear landing this cycle is not bypassed.
   always_comb begin
      hazard = (i_issue_use_rs1 && busy_q[i_issue_rs1]) ||
               (i_issue_use_rs2 && busy_q[i_issue_rs2]) ||
               busy_q[i_issue_rd];
      full           = i_issue_long && (out_cnt_q == MAX_CNT);
      o_issue_stall  = i_issue_valid && (hazard || full || starve_hold_q);
      issue_long_acc = i_issue_valid && !o_issue_stall && i_issue_long;
      o_wbb_ready    = !i_wba_valid;
      b_acc          = i_wbb_valid && o_wbb_ready;
   end

   // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
   always_comb begin
      busy_d = busy_q;
      if (b_acc) begin
         busy_d[i_wbb_rd] = 1'b0;
      end
      if (issue_long_acc && (i_issue_rd != 5'd0)) begin
         busy_d[i_issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;

      out_cnt_d = out_cnt_q;
      if (issue_long_acc && !b_acc) begin
         out_cnt_d = out_cnt_q + 4'd1;
      end else if (!issue_long_acc && b_acc && (out_cnt_q != 4'd0)) begin
         out_cnt_d = out_cnt_q - 4'd1;
      end

      wait_cnt_d = 8'd0;
      if (i_wbb_valid && !o_wbb_ready) begin
         wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
      end

      starve_hold_d = starve_hold_q || (wait_cnt_d >= STARVE_LIM);
      if (b_acc) begin
         starve_hold_d = 1'b0;
      end

      sb_err_d = sb_err_q || (b_acc && (i_wbb_rd != 5'd0) && !busy_q[i_wbb_rd]);
   end

   // x0 writes still win the port and complete their handshake, but never raise the write enable.
   always_comb begin
      rd_wren_d = 1'b0;
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
      if (i_wba_valid) begin
         rd_wren_d = (i_wba_rd != 5'd0);
         rd_addr_d = i_wba_rd;
         rd_data_d = i_wba_data;
      end else if (b_acc) begin
         rd_wren_d = (i_wbb_rd != 5'd0);
         rd_addr_d = i_wbb_rd;
         rd_data_d = i_wbb_data;
      end
   end

   // NOTE: state registers use non-blocking assignments only; the comb blocks above use blocking.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         busy_q        <= '0;
         out_cnt_q     <= '0;
         wait_cnt_q    <= '0;
         starve_hold_q <= 1'b0;
         rd_wren_q     <= 1'b0;
         rd_addr_q     <= '0;
         rd_data_q     <= '0;
         sb_err_q      <= 1'b0;
      end else begin
         busy_q        <= busy_d;
         out_cnt_q     <= out_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         starve_hold_q <= starve_hold_d;
         rd_wren_q     <= rd_wren_d;
         rd_addr_q     <= rd_addr_d;
         rd_data_q     <= rd_data_d;
         sb_err_q      <= sb_err_d;
      end
   end

   assign o_rd_wren = rd_wren_q;
   assign o_rd_addr = rd_addr_q;
   assign o_rd_data = rd_data_q;
   assign o_busy    = busy_q;
   assign o_sb_err  = sb_err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: directed scenarios plus randomized traffic,
// checked against a cycle-level behavioural model and a queue of expected register writes.
module tb_regfile_wb_scheduler;

   localparam int MAX_OUT = 4;
   localparam int STARVE  = 8;

   logic        i_clk;
   logic        i_reset_n;
   logic        i_issue_valid;
   logic [4:0]  i_issue_rd, i_issue_rs1, i_issue_rs2;
   logic        i_issue_use_rs1, i_issue_use_rs2, i_issue_long;
   logic        o_issue_stall;
   logic        i_wba_valid;
   logic [4:0]  i_wba_rd;
   logic [31:0] i_wba_data;
   logic        i_wbb_valid;
   logic [4:0]  i_wbb_rd;
   logic [31:0] i_wbb_data;
   logic        o_wbb_ready;
   logic        o_rd_wren;
   logic [4:0]  o_rd_addr;
   logic [31:0] o_rd_data;
   logic [31:0] o_busy;
   logic        o_sb_err;

   regfile_wb_scheduler #(
      .MAX_OUTSTANDING(MAX_OUT),
      .STARVE_LIMIT   (STARVE)
   ) dut (
      .i_clk          (i_clk),
      .i_reset_n      (i_reset_n),
      .i_issue_valid  (i_issue_valid),
      .i_issue_rd     (i_issue_rd),
      .i_issue_rs1    (i_issue_rs1),
      .i_issue_rs2    (i_issue_rs2),
      .i_issue_use_rs1(i_issue_use_rs1),
      .i_issue_use_rs2(i_issue_use_rs2),
      .i_issue_long   (i_issue_long),
      .o_issue_stall  (o_issue_stall),
      .i_wba_valid    (i_wba_valid),
      .i_wba_rd       (i_wba_rd),
      .i_wba_data     (i_wba_data),
      .i_wbb_valid    (i_wbb_valid),
      .i_wbb_rd       (i_wbb_rd),
      .i_wbb_data     (i_wbb_data),
      .o_wbb_ready    (o_wbb_ready),
      .o_rd_wren      (o_rd_wren),
      .o_rd_addr      (o_rd_addr),
      .o_rd_data      (o_rd_data),
      .o_busy         (o_busy),
      .o_sb_err       (o_sb_err)
   );

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   int  n_pass  = 0;
   int  n_total = 0;
   int  cyc     = 0;
   wr_t exp_q[$];

   // Reference model state, expressed as plain counts and a bit vector.
   bit [31:0] m_busy;
   int        m_out;
   int        m_wait;
   bit        m_hold;
   bit        m_err;

   bit        last_iacc, last_bacc, last_stall_dut;

   // Random-phase B driver state.
   logic [4:0]  pend_rd[$];
   bit          b_pend;
   logic [4:0]  b_rd;
   logic [31:0] b_data;

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   always @(posedge i_clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every write presented by the DUT must match the head of the expected queue.
   always @(negedge i_clk) begin
      if (i_reset_n && o_rd_wren) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", o_rd_addr, o_rd_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(o_rd_addr), 32'(e.addr));
            check("wr_data", o_rd_data, e.data);
            check("wr_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic model_reset();
      m_busy = '0;
      m_out  = 0;
      m_wait = 0;
      m_hold = 1'b0;
      m_err  = 1'b0;
   endtask

   // One clock cycle: drive inputs, compare against the model, advance the model.
   // Entered and left 1 time unit after a rising edge.
   task automatic cycle(input bit iv, input logic [4:0] ird, input logic [4:0] irs1,
                        input logic [4:0] irs2, input bit iu1, input bit iu2, input bit il,
                        input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit bv, input logic [4:0] brd, input logic [31:0] bd);
      bit  exp_stall, iacc, bacc;
      wr_t w;
      i_issue_valid = iv;   i_issue_rd = ird;     i_issue_rs1 = irs1; i_issue_rs2 = irs2;
      i_issue_use_rs1 = iu1; i_issue_use_rs2 = iu2; i_issue_long = il;
      i_wba_valid = av; i_wba_rd = ard; i_wba_data = ad;
      i_wbb_valid = bv; i_wbb_rd = brd; i_wbb_data = bd;
      #1;
      exp_stall = iv && ((iu1 && m_busy[irs1]) || (iu2 && m_busy[irs2]) || m_busy[ird] ||
                         (il && m_out == MAX_OUT) || m_hold);
      check("issue_stall", 32'(o_issue_stall), 32'(exp_stall));
      check("wbb_ready", 32'(o_wbb_ready), 32'(!av));
      check("busy", o_busy, m_busy);
      check("sb_err", 32'(o_sb_err), 32'(m_err));
      last_stall_dut = o_issue_stall;
      iacc = iv && !exp_stall;
      bacc = bv && !av;
      w.cyc = cyc + 1;
      if (av && ard != 5'd0) begin
         w.addr = ard; w.data = ad; exp_q.push_back(w);
      end else if (bacc && brd != 5'd0) begin
         w.addr = brd; w.data = bd; exp_q.push_back(w);
      end
      if (bacc) begin
         if (brd != 5'd0 && !m_busy[brd]) m_err = 1'b1;
         m_busy[brd] = 1'b0;
      end
      if (iacc && il && ird != 5'd0) m_busy[ird] = 1'b1;
      if (iacc && il && !bacc) m_out++;
      else if (bacc && !(iacc && il) && m_out > 0) m_out--;
      if (bv && av) m_wait = (m_wait < 255) ? m_wait + 1 : 255;
      else m_wait = 0;
      if (bacc) m_hold = 1'b0;
      else if (m_wait >= STARVE) m_hold = 1'b1;
      last_iacc = iacc;
      last_bacc = bacc;
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic issue_long(input logic [4:0] rd);
      cycle(1, rd, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic b_write(input logic [4:0] rd, input logic [31:0] d);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, rd, d);
   endtask

   task automatic rand_cycle(input bit drain);
      bit          iv, il, av;
      logic [4:0]  ird, irs1, irs2, ard;
      bit          iu1, iu2;
      if (!b_pend && pend_rd.size() > 0 && (drain || $urandom_range(2) == 0)) begin
         int idx;
         idx = $urandom_range(pend_rd.size() - 1);
         b_rd = pend_rd[idx];
         pend_rd.delete(idx);
         b_data = $urandom;
         b_pend = 1'b1;
      end
      iv   = !drain && ($urandom_range(9) < 7);
      il   = $urandom_range(9) < 4;
      ird  = 5'($urandom_range(7));
      irs1 = 5'($urandom_range(7));
      irs2 = 5'($urandom_range(7));
      iu1  = $urandom_range(1) == 1;
      iu2  = $urandom_range(1) == 1;
      av   = !drain && ($urandom_range(3) != 0);
      ard  = 5'($urandom_range(31));
      cycle(iv, ird, irs1, irs2, iu1, iu2, il, av, ard, $urandom, b_pend, b_rd, b_data);
      if (last_iacc && il) pend_rd.push_back(ird);
      if (last_bacc) b_pend = 1'b0;
   endtask

   initial begin
      i_reset_n = 1'b0;
      i_issue_valid = 0; i_issue_rd = 0; i_issue_rs1 = 0; i_issue_rs2 = 0;
      i_issue_use_rs1 = 0; i_issue_use_rs2 = 0; i_issue_long = 0;
      i_wba_valid = 0; i_wba_rd = 0; i_wba_data = 0;
      i_wbb_valid = 0; i_wbb_rd = 0; i_wbb_data = 0;
      b_pend = 0; b_rd = 0; b_data = 0;
      model_reset();
      #12;
      check("reset_wren", 32'(o_rd_wren), 0);
      check("reset_addr", 32'(o_rd_addr), 0);
      check("reset_data", o_rd_data, 0);
      check("reset_busy", o_busy, 0);
      check("reset_err", 32'(o_sb_err), 0);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      @(posedge i_clk);
      #1;

      // RAW hazard on x5 released by B write-back.
      issue_long(5);
      check("long_x5_busy", o_busy, 32'h0000_0020);
      cycle(1, 8, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("raw_stalled", 32'(last_stall_dut), 1);
      cycle(1, 8, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 8, 5, 0, 1, 0, 0, 0, 0, 0, 1, 5, 32'hDEAD_BEEF);
      check("raw_no_bypass", 32'(last_stall_dut), 1);
      cycle(1, 8, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("raw_released", 32'(last_stall_dut), 0);

      // A/B collision: A wins, B goes next cycle.
      issue_long(7);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h11, 1, 7, 32'h22);
      b_write(7, 32'h22);
      idle();

      // Outstanding limit.
      for (int r = 1; r <= 4; r++) issue_long(5'(r));
      issue_long(10);
      check("full_stalled", 32'(last_stall_dut), 1);
      cycle(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("short_accepted", 32'(last_stall_dut), 0);
      cycle(1, 10, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'hA1);
      issue_long(10);
      check("fifth_accepted", 32'(last_stall_dut), 0);
      b_write(2, 32'hA2);
      b_write(3, 32'hA3);
      b_write(4, 32'hA4);
      b_write(10, 32'hAA);

      // Starvation of B under continuous A traffic.
      issue_long(20);
      for (int k = 0; k < 12; k++)
         cycle(1, 21, 0, 0, 0, 0, 0, 1, 5'(k + 1), $urandom, 1, 20, 32'h2020);
      check("starve_blocks_issue", 32'(last_stall_dut), 1);
      cycle(1, 21, 0, 0, 0, 0, 0, 0, 0, 0, 1, 20, 32'h2020);
      check("starve_hold_on_accept", 32'(last_stall_dut), 1);
      cycle(1, 21, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("starve_released", 32'(last_stall_dut), 0);

      // x0 long op counts as outstanding but never sets busy.
      issue_long(0);
      check("x0_busy_clear", o_busy, 0);
      for (int r = 1; r <= 3; r++) issue_long(5'(r));
      issue_long(4);
      check("x0_counts_outstanding", 32'(last_stall_dut), 1);
      b_write(0, 32'hFFFF_0000);
      issue_long(4);
      check("x0_completion_frees_slot", 32'(last_stall_dut), 0);
      for (int r = 1; r <= 4; r++) b_write(5'(r), 32'hB0 + 32'(r));
      check("no_err_yet", 32'(o_sb_err), 0);
      b_write(12, 32'h1212);
      check("sb_err_set", 32'(o_sb_err), 1);
      idle();
      idle();
      check("sb_err_sticky", 32'(o_sb_err), 1);

      // Reset in the middle of a write with a long op pending.
      cycle(1, 6, 0, 0, 0, 0, 1, 1, 3, 32'h3333, 0, 0, 0);
      check("pre_reset_wren", 32'(o_rd_wren), 1);
      #1;
      i_reset_n = 1'b0;
      #1;
      check("midreset_wren", 32'(o_rd_wren), 0);
      check("midreset_addr", 32'(o_rd_addr), 0);
      check("midreset_data", o_rd_data, 0);
      check("midreset_busy", o_busy, 0);
      check("midreset_err", 32'(o_sb_err), 0);
      exp_q.delete();
      model_reset();
      i_issue_valid = 0; i_wba_valid = 0; i_wbb_valid = 0;
      @(negedge i_clk);
      #1;
      i_reset_n = 1'b1;
      @(posedge i_clk);
      #1;
      idle();

      // Randomized traffic, then drain every pending long op.
      for (int n = 0; n < 3000; n++) rand_cycle(1'b0);
      for (int n = 0; n < 200 && (pend_rd.size() > 0 || b_pend); n++) rand_cycle(1'b1);
      check("drain_complete", 32'(pend_rd.size() + int'(b_pend)), 0);
      idle();
      idle();
      check("final_busy", o_busy, 0);
      check("exp_queue_empty", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
